// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage and IF/ID pipeline register of the MIPS
//            core. Keeps the PC, issues one-outstanding-request fetches over
//            a ready/valid instruction-memory bus, buffers the returned word
//            (with a one-entry skid buffer for decode back-pressure) and
//            presents instruction, opcode and PC+4 to decode. Supports decode
//            stall and branch/jump redirect (flush).
//
// Ports    : clk             core clock, rising edge
//            rst_n           asynchronous active-low reset
//            stall           decode cannot accept; hold IF/ID contents
//            redirect        branch/jump taken; flush and refetch
//            redirect_target new PC (bits [1:0] ignored)
//            imem_req        fetch request valid
//            imem_addr       fetch address, word aligned
//            imem_ready      memory accepts request this cycle
//            imem_rvalid     one-cycle read-data-valid pulse
//            imem_rdata      fetched instruction
//            id_valid        IF/ID holds a valid instruction
//            id_instr        instruction to decode
//            id_opcode       id_instr[31:26]
//            id_pc4          address of id_instr + 4
//
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [31:0] id_pc4
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_DISCARD = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_nxt;

    logic [31:0] pc;
    logic [31:0] req_pc4;

    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;

    logic        accept;
    logic        resp;
    logic        slot_free;

    logic        id_valid_nxt;
    logic [31:0] id_instr_nxt;
    logic [31:0] id_pc4_nxt;
    logic        skid_valid_nxt;
    logic [31:0] skid_instr_nxt;
    logic [31:0] skid_pc4_nxt;

    // A redirect in ISSUE refuses the handshake so the stale address is never
    // fetched; a redirect in WAIT drops any same-cycle response.
    assign accept    = (state == S_ISSUE) && imem_ready && !redirect;
    assign resp      = (state == S_WAIT) && imem_rvalid && !redirect;
    // IF/ID can take a new word when it is empty or being consumed this cycle.
    assign slot_free = !id_valid || !stall;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // Response still in flight must be swallowed later.
                    state_nxt = imem_rvalid ? S_ISSUE : S_DISCARD;
                end else if (imem_rvalid) begin
                    state_nxt = skid_valid_nxt ? S_HOLD : S_ISSUE;
                end
            end
            S_HOLD: begin
                if (redirect || !skid_valid) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid) begin
                    state_nxt = S_ISSUE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_req = (state == S_ISSUE);
    end

    assign imem_addr = pc;
    assign id_opcode = id_instr[31:26];

    // ------------------------------------------------------------------
    // IF/ID and skid-buffer next values
    // ------------------------------------------------------------------
    always_comb begin
        id_valid_nxt   = id_valid;
        id_instr_nxt   = id_instr;
        id_pc4_nxt     = id_pc4;
        skid_valid_nxt = skid_valid;
        skid_instr_nxt = skid_instr;
        skid_pc4_nxt   = skid_pc4;

        if (redirect) begin
            id_valid_nxt   = 1'b0;
            id_instr_nxt   = NOP_INSTR;
            skid_valid_nxt = 1'b0;
        end else if (slot_free) begin
            // The skid word is older than any response, so it goes first.
            // A response cannot coincide with a full skid (FSM is in HOLD).
            if (skid_valid) begin
                id_valid_nxt   = 1'b1;
                id_instr_nxt   = skid_instr;
                id_pc4_nxt     = skid_pc4;
                skid_valid_nxt = 1'b0;
            end else if (resp) begin
                id_valid_nxt   = 1'b1;
                id_instr_nxt   = imem_rdata;
                id_pc4_nxt     = req_pc4;
            end else begin
                id_valid_nxt   = 1'b0;
                id_instr_nxt   = NOP_INSTR;
            end
        end else if (resp) begin
            skid_valid_nxt = 1'b1;
            skid_instr_nxt = imem_rdata;
            skid_pc4_nxt   = req_pc4;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            req_pc4    <= 32'h0000_0000;
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            id_pc4     <= 32'h0000_0000;
            skid_valid <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc4   <= 32'h0000_0000;
        end else begin
            if (redirect) begin
                pc <= redirect_target & ~32'd3;
            end else if (accept) begin
                // Modulo-2^32 increment: 0xFFFF_FFFC wraps to 0.
                pc      <= pc + 32'd4;
                req_pc4 <= pc + 32'd4;
            end
            id_valid   <= id_valid_nxt;
            id_instr   <= id_instr_nxt;
            id_pc4     <= id_pc4_nxt;
            skid_valid <= skid_valid_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc4   <= skid_pc4_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Directed self-checking bench for if_stage. A second instance
//            with RESET_PC = 0xFFFF_FFFC covers PC wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [31:0] id_pc4;

    logic        wr_req;
    logic [31:0] wr_addr;
    logic        wr_rvalid;
    logic [31:0] wr_rdata;
    logic        wr_valid;
    logic [31:0] wr_instr;
    logic [5:0]  wr_opcode;
    logic [31:0] wr_pc4;

    int n_total = 0;
    int n_bad   = 0;
    int lat     = 0;

    if_stage u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_opcode       (id_opcode),
        .id_pc4          (id_pc4)
    );

    if_stage #(
        .RESET_PC  (32'hFFFF_FFFC),
        .NOP_INSTR (32'h0000_0000)
    ) u_wrap (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (1'b0),
        .redirect        (1'b0),
        .redirect_target (32'h0000_0000),
        .imem_req        (wr_req),
        .imem_addr       (wr_addr),
        .imem_ready      (1'b1),
        .imem_rvalid     (wr_rvalid),
        .imem_rdata      (wr_rdata),
        .id_valid        (wr_valid),
        .id_instr        (wr_instr),
        .id_opcode       (wr_opcode),
        .id_pc4          (wr_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h8C01_0004;
        else if (a == 32'h4) return 32'h2002_0005;
        else                 return 32'h1000_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Memory model for the main DUT: requests seen at a falling edge are
    // accepted on the next rising edge; the response is presented lat+1
    // cycles later as a one-cycle pulse.
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend        = 1'b0;
        cnt         = 0;
        paddr       = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(paddr);
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (rst_n && imem_req && imem_ready && !redirect) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem_addr;
            end
        end
    end

    // Single-cycle-latency memory for the wrap instance.
    initial begin
        logic        pend;
        logic [31:0] paddr;
        pend      = 1'b0;
        paddr     = 32'h0;
        wr_rvalid = 1'b0;
        wr_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            wr_rvalid = 1'b0;
            if (pend) begin
                wr_rvalid = 1'b1;
                wr_rdata  = word(paddr);
                pend      = 1'b0;
            end
            if (rst_n && wr_req) begin
                pend  = 1'b1;
                paddr = wr_addr;
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        imem_ready      = 1'b1;

        // Reset values
        tick(2);
        chk("rst_req",    {31'h0, imem_req}, 32'h0);
        chk("rst_addr",   imem_addr,         32'h0);
        chk("rst_valid",  {31'h0, id_valid}, 32'h0);
        chk("rst_instr",  id_instr,          32'h0);
        chk("rst_pc4",    id_pc4,            32'h0);
        rst_n = 1'b1;

        // Basic fetch
        tick(1);                                        // E1: ISSUE
        chk("e1_req",     {31'h0, imem_req}, 32'h1);
        chk("e1_addr",    imem_addr,         32'h0);
        tick(1);                                        // E2: WAIT
        chk("e2_req",     {31'h0, imem_req}, 32'h0);
        tick(1);                                        // E3: first word
        chk("w1_valid",   {31'h0, id_valid}, 32'h1);
        chk("w1_instr",   id_instr,          32'h8C01_0004);
        chk("w1_opcode",  {26'h0, id_opcode}, 32'h23);
        chk("w1_pc4",     id_pc4,            32'h4);
        chk("e3_addr",    imem_addr,         32'h4);
        chk("wrap_pc4",   wr_pc4,            32'h0);
        chk("wrap_valid", {31'h0, wr_valid}, 32'h1);
        chk("wrap_addr2", wr_addr,           32'h0);
        tick(2);                                        // E5: second word
        chk("w2_instr",   id_instr,          32'h2002_0005);
        chk("w2_opcode",  {26'h0, id_opcode}, 32'h08);
        chk("w2_pc4",     id_pc4,            32'h8);
        chk("e5_addr",    imem_addr,         32'h8);

        // Stall with response arriving -> skid + HOLD
        stall = 1'b1;
        tick(2);                                        // E7
        chk("st_req",     {31'h0, imem_req}, 32'h0);
        chk("st_instr",   id_instr,          32'h2002_0005);
        tick(3);                                        // E10
        chk("st_hold",    id_instr,          32'h2002_0005);
        chk("st_pc4",     id_pc4,            32'h8);
        chk("st_req2",    {31'h0, imem_req}, 32'h0);
        stall = 1'b0;
        tick(1);                                        // E11: skid drains
        chk("sk_instr",   id_instr,          32'h1000_0008);
        chk("sk_pc4",     id_pc4,            32'hC);
        chk("sk_req",     {31'h0, imem_req}, 32'h0);
        tick(1);                                        // E12: ISSUE 0xC
        chk("sk_nodup",   {31'h0, id_valid}, 32'h0);
        chk("e12_addr",   imem_addr,         32'hC);
        chk("e12_req",    {31'h0, imem_req}, 32'h1);
        tick(2);                                        // E14
        chk("w4_instr",   id_instr,          32'h1000_000C);

        // Redirect in WAIT with the response still pending
        stall = 1'b1;
        lat   = 2;
        tick(1);                                        // E15: WAIT
        redirect        = 1'b1;
        redirect_target = 32'h0000_0103;
        tick(1);                                        // E16: DISCARD
        chk("rd_valid",   {31'h0, id_valid}, 32'h0);
        chk("rd_instr",   id_instr,          32'h0);
        chk("rd_req",     {31'h0, imem_req}, 32'h0);
        redirect = 1'b0;
        stall    = 1'b0;
        lat      = 0;
        tick(2);                                        // E18: ISSUE target
        chk("rd_addr",    imem_addr,         32'h100);
        chk("rd_req2",    {31'h0, imem_req}, 32'h1);
        chk("rd_drop",    {31'h0, id_valid}, 32'h0);
        tick(2);                                        // E20
        chk("rd_instr2",  id_instr,          32'h1000_0100);
        chk("rd_pc4",     id_pc4,            32'h104);

        // Redirect coinciding with a response while stalled
        stall = 1'b1;
        tick(1);                                        // E21: WAIT
        redirect        = 1'b1;
        redirect_target = 32'h0000_0200;
        tick(1);                                        // E22
        chk("rr_valid",   {31'h0, id_valid}, 32'h0);
        chk("rr_req",     {31'h0, imem_req}, 32'h1);
        chk("rr_addr",    imem_addr,         32'h200);
        redirect = 1'b0;
        stall    = 1'b0;
        tick(1);                                        // E23
        chk("rr_noskid",  {31'h0, id_valid}, 32'h0);
        tick(1);                                        // E24
        chk("rr_instr",   id_instr,          32'h1000_0200);
        chk("rr_pc4",     id_pc4,            32'h204);

        // Memory not ready for three cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("nr_req",  {31'h0, imem_req}, 32'h1);
            chk("nr_addr", imem_addr,         32'h204);
        end
        imem_ready = 1'b1;
        tick(1);                                        // E28: WAIT
        chk("nr_wait",    {31'h0, imem_req}, 32'h0);
        tick(1);                                        // E29
        chk("nr_instr",   id_instr,          32'h1000_0204);
        chk("nr_pc4",     id_pc4,            32'h208);

        // Asynchronous reset in the middle of WAIT
        lat = 3;
        tick(1);                                        // E30: WAIT
        rst_n = 1'b0;
        #1;
        chk("ar_req",     {31'h0, imem_req}, 32'h0);
        chk("ar_addr",    imem_addr,         32'h0);
        chk("ar_valid",   {31'h0, id_valid}, 32'h0);
        chk("ar_instr",   id_instr,          32'h0);
        chk("ar_opcode",  {26'h0, id_opcode}, 32'h0);
        chk("ar_pc4",     id_pc4,            32'h0);
        chk("ar_wrap",    wr_addr,           32'hFFFF_FFFC);
        tick(3);
        chk("ar_hold",    {31'h0, imem_req}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the MIPS core.
- Holds the PC and issues one-outstanding-request fetches to instruction memory over a ready/valid bus.
- Buffers the returned word and presents instruction, opcode and PC+4 to the decode stage, whose control unit consumes id_opcode.
- Supports downstream stall and branch/jump redirect (flush).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, value driven on id_instr when the slot is empty, reset or flushed.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  decode cannot accept; hold IF/ID contents.
- redirect  input  1  branch/jump taken; flush and refetch.
- redirect_target  input  32  new PC; bits [1:0] are ignored and forced to 0.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address, word aligned.
- imem_ready  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  one-cycle pulse: read data valid.
- imem_rdata  input  32  fetched instruction.
- id_valid  output  1  IF/ID holds a valid instruction.
- id_instr  output  32  instruction to decode.
- id_opcode  output  6  id_instr[31:26], combinational.
- id_pc4  output  32  address of id_instr + 4.

Behaviour:
- Clock, reset and polarity: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc4=0. Skid buffer is empty. State is IDLE.
- States:
  - IDLE: entered from reset; go to ISSUE next cycle.
  - ISSUE: imem_req=1, imem_addr=pc. On imem_req&&imem_ready: latch req_pc4=pc+4, set pc<=pc+4, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid, deliver the word (see below), then go to ISSUE. If the skid buffer is full after delivery, go to HOLD instead.
  - HOLD: imem_req=0. Go to ISSUE once the skid buffer is empty.
  - DISCARD: imem_req=0. On imem_rvalid, drop the data and go to ISSUE.
- Handshake rules:
  - At most one outstanding request.
  - While in ISSUE, imem_addr is stable unless a redirect occurs.
  - A new request may be issued in the same cycle the previous response is delivered (ISSUE is entered the following cycle).
- Delivery of a response word:
  - IF/ID free (!id_valid || !stall): load id_instr=imem_rdata, id_pc4=req_pc4, id_valid=1.
  - Otherwise: write into the one-entry skid buffer.
- IF/ID advance:
  - When id_valid && !stall, the slot is consumed.
  - It is refilled the same cycle from the skid buffer if full, else from a concurrent response.
  - If neither source is available, id_valid=0 and id_instr=NOP_INSTR.
  - With stall=1, id_* hold every bit.
- Redirect has the highest priority and overrides stall:
  - pc<=redirect_target & ~3.
  - id_valid<=0, id_instr<=NOP_INSTR, skid buffer cleared.
  - In ISSUE: request is not accepted that cycle. Next cycle imem_addr=new pc, imem_req stays 1.
  - In WAIT: a response in the same cycle is dropped; go to ISSUE. With no response that cycle, go to DISCARD.
  - In HOLD or IDLE: go to ISSUE.
  - In DISCARD: stay in DISCARD with the new pc. A response in the same cycle is dropped; go to ISSUE.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- id_opcode is always id_instr[31:26], so it reads 0 when the slot is empty.

Test Plan:
- Reset then imem_ready=1 and 1-cycle rvalid latency, words 0x8C010004, 0x20020005 -> imem_addr 0x0, 0x4, ...; id_instr shows 0x8C010004 with id_opcode=6'h23 and id_pc4=0x4, then 0x20020005 with opcode 6'h08 and pc4 0x8.
- stall=1 for 5 cycles while a response arrives -> id_* unchanged and the skid buffer holds the new word; FSM in HOLD and imem_req=0. Release stall -> skid word appears next cycle, in order, with no loss or duplication.
- redirect=1 with target 0x0000_0103 while in WAIT -> id_valid=0 next cycle; pending response dropped; next request to imem_addr=0x0000_0100.
- redirect and imem_rvalid in the same cycle, with stall=1 -> response discarded, skid cleared, id_valid=0; next fetch from the target.
- imem_ready=0 for 3 cycles -> imem_req=1 and imem_addr stable throughout; one request is accepted on ready.
- RESET_PC=32'hFFFF_FFFC -> first id_pc4=0x0 and second fetch address 0x0. Assert rst_n low mid-WAIT -> all outputs return to reset values immediately.
